// File: rtl/dff_checker_if.sv
// Bus between the flip-flop stimulus side and the dff_checker responder.
// The master drives run control plus the D/Q/QB observed around the
// flip-flop under test; the slave (checker) returns run status.
interface dff_checker_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             d;
  logic             q;
  logic             qb;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [IDX_W-1:0] first_err_idx;

  modport master (
    output en, d, q, qb,
    input  busy, done, pass, fail, err_cnt, first_err_idx
  );

  modport slave (
    input  en, d, q, qb,
    output busy, done, pass, fail, err_cnt, first_err_idx
  );
endinterface

// File: rtl/dff_checker.sv
// Self-checking responder for a D flip-flop under test. It tracks the bit
// the flip-flop should be holding (exp_r), compares Q/QB against it over a
// fixed window of N_CHECKS samples, and reports a saturating error count,
// the index of the first bad sample and a PASS/FAIL verdict.
module dff_checker #(
  parameter int N_CHECKS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 8
) (
  input logic          clk,
  input logic          rst,
  dff_checker_if.slave bus
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_PRIME = 2'd1;
  localparam logic [1:0]       ST_CHECK = 2'd2;
  localparam logic [1:0]       ST_DONE  = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHECKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // A sample is bad when either output disagrees with the expectation, so
  // Q == QB can never pass.
  function automatic logic sample_bad(input logic q, input logic qb, input logic exp_bit);
    return (q != exp_bit) || (qb != ~exp_bit);
  endfunction

  logic [1:0]       state_r;
  logic             exp_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [IDX_W-1:0] first_err_idx_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic             fail_r;

  logic [1:0]       state_nxt_s;
  logic             exp_nxt_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] err_cnt_nxt_s;
  logic [IDX_W-1:0] first_err_idx_nxt_s;
  logic             pass_nxt_s;
  logic             fail_nxt_s;
  logic             mismatch_s;
  logic [CNT_W-1:0] err_bump_s;

  assign mismatch_s = sample_bad(bus.q, bus.qb, exp_r);
  // Counter sticks at all-ones instead of wrapping back to a clean-looking 0.
  assign err_bump_s = (mismatch_s && (err_cnt_r != CNT_MAX)) ? (err_cnt_r + CNT_W'(1)) : err_cnt_r;

  // Next-state and next-result computation for the run sequencer.
  always_comb begin
    state_nxt_s         = state_r;
    exp_nxt_s           = exp_r;
    idx_nxt_s           = idx_r;
    err_cnt_nxt_s       = err_cnt_r;
    first_err_idx_nxt_s = first_err_idx_r;
    pass_nxt_s          = 1'b0;
    fail_nxt_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.en) begin
          state_nxt_s         = ST_PRIME;
          idx_nxt_s           = {IDX_W{1'b0}};
          err_cnt_nxt_s       = {CNT_W{1'b0}};
          first_err_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        // No expectation exists yet, so this edge only loads exp.
        if (!bus.en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          exp_nxt_s   = bus.d;
          state_nxt_s = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!bus.en) begin
          // Abort: partial counts stay visible until the next start.
          state_nxt_s = ST_IDLE;
        end else begin
          err_cnt_nxt_s = err_bump_s;
          if (mismatch_s && (err_cnt_r == {CNT_W{1'b0}})) begin
            first_err_idx_nxt_s = idx_r;
          end else begin
            first_err_idx_nxt_s = first_err_idx_r;
          end
          exp_nxt_s = bus.d;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_DONE;
            pass_nxt_s  = (err_bump_s == {CNT_W{1'b0}});
            fail_nxt_s  = (err_bump_s != {CNT_W{1'b0}});
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!bus.en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
          pass_nxt_s  = pass_r;
          fail_nxt_s  = fail_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; status flags decoded from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      exp_r           <= 1'b0;
      idx_r           <= {IDX_W{1'b0}};
      err_cnt_r       <= {CNT_W{1'b0}};
      first_err_idx_r <= {IDX_W{1'b0}};
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
      fail_r          <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      exp_r           <= exp_nxt_s;
      idx_r           <= idx_nxt_s;
      err_cnt_r       <= err_cnt_nxt_s;
      first_err_idx_r <= first_err_idx_nxt_s;
      busy_r          <= (state_nxt_s == ST_PRIME) || (state_nxt_s == ST_CHECK);
      done_r          <= (state_nxt_s == ST_DONE);
      pass_r          <= pass_nxt_s;
      fail_r          <= fail_nxt_s;
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.pass          = pass_r;
  assign bus.fail          = fail_r;
  assign bus.err_cnt       = err_cnt_r;
  assign bus.first_err_idx = first_err_idx_r;

endmodule
